// File: rtl/simple_pipe_pkg.sv
// rtl/simple_pipe_pkg.sv - shared constants and the stage adder for simple_pipe
// SIMPLE_PIPE_SAT_EN selects saturating instead of wrapping stage adds.
package simple_pipe_pkg;

  localparam int DEF_WIDTH     = 8;
  localparam int DEF_DEPTH     = 5;
  localparam int DEF_STEP      = 1;
  localparam int DEF_FINAL_ADD = 2;

  // Widest datapath the adder handles; callers zero-extend into it.
  localparam int MAX_W = 64;

  // Returns {saturated, result}; a and b must already fit in w bits.
  function automatic logic [MAX_W:0] add_c(input logic [MAX_W-1:0] a,
                                           input logic [MAX_W-1:0] b,
                                           input int unsigned w);
    logic [MAX_W-1:0] lim;
`ifdef SIMPLE_PIPE_SAT_EN
    logic [MAX_W:0] sum;
    lim = {MAX_W{1'b1}} >> (MAX_W - w);
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, lim}) begin
      return {1'b1, lim};
    end
    return sum;
`else
    logic [MAX_W-1:0] sum;
    lim = {MAX_W{1'b1}} >> (MAX_W - w);
    sum = a + b;
    return {1'b0, sum & lim};
`endif
  endfunction

endpackage

// File: rtl/simple_pipe_if.sv
// rtl/simple_pipe_if.sv - upstream/downstream handshake and status bundle of simple_pipe
interface simple_pipe_if
  import simple_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int DEPTH = DEF_DEPTH
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [OCC_W-1:0] occupancy;
  logic             sat_flag;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy, sat_flag
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy, sat_flag
  );

endinterface

// File: rtl/simple_pipe_stage.sv
// rtl/simple_pipe_stage.sv - one elastic register stage adding a constant on load
// Adder behaviour (wrap or saturate) follows SIMPLE_PIPE_SAT_EN through add_c.
module simple_pipe_stage
  import simple_pipe_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int ADD   = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_v,
  input  logic [WIDTH-1:0] in_d,
  input  logic             out_r,
  output logic             v,
  output logic [WIDTH-1:0] d,
  output logic             rdy,
  output logic             sat
);
  localparam logic [WIDTH-1:0] ADD_W = WIDTH'(ADD);

  logic             r_v;
  logic [WIDTH-1:0] r_d;
  logic [MAX_W:0]   w_sum;

  assign w_sum = add_c(MAX_W'(in_d), MAX_W'(ADD_W), WIDTH);
  assign rdy   = !r_v || out_r;
  // Upper bits are zero unless the saturate flag is set.
  assign sat   = rdy && in_v && (|w_sum[MAX_W:WIDTH]);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_v <= 1'b0;
      r_d <= '0;
    end else if (rdy) begin
      r_v <= in_v;
      r_d <= w_sum[WIDTH-1:0];
    end
  end

  assign v = r_v;
  assign d = r_d;

endmodule

// File: rtl/simple_pipe.sv
// rtl/simple_pipe.sv - elastic DEPTH-stage add pipeline with combinational ready chain
// With SIMPLE_PIPE_SAT_EN undefined the stages never report saturation, so sat_flag stays 0.
module simple_pipe
  import simple_pipe_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int DEPTH     = DEF_DEPTH,
  parameter int STEP      = DEF_STEP,
  parameter int FINAL_ADD = DEF_FINAL_ADD
) (
  input  logic         clk,
  input  logic         reset,
  simple_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(DEPTH + 1);

  logic [DEPTH:0]   w_rdy;
  logic [DEPTH-1:0] w_v;
  logic [DEPTH-1:0] w_in_v;
  logic [DEPTH-1:0] w_sat;
  logic [WIDTH-1:0] w_d    [DEPTH];
  logic [WIDTH-1:0] w_in_d [DEPTH];
  logic             r_sat_flag;

  assign w_rdy[DEPTH] = bus.out_ready;
  assign w_in_v       = {w_v[DEPTH-2:0], bus.in_valid};

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_head
      assign w_in_d[i] = bus.in_data;
    end else begin : g_body
      assign w_in_d[i] = w_d[i-1];
    end

    simple_pipe_stage #(
      .WIDTH (WIDTH),
      .ADD   ((i == 0) ? 0 : (i == DEPTH - 1) ? FINAL_ADD : STEP)
    ) u_stage (
      .clk   (clk),
      .reset (reset),
      .in_v  (w_in_v[i]),
      .in_d  (w_in_d[i]),
      .out_r (w_rdy[i+1]),
      .v     (w_v[i]),
      .d     (w_d[i]),
      .rdy   (w_rdy[i]),
      .sat   (w_sat[i])
    );
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sat_flag <= 1'b0;
    end else begin
      r_sat_flag <= r_sat_flag | (|w_sat);
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = w_v[DEPTH-1];
  assign bus.out_data  = w_d[DEPTH-1];
  assign bus.occupancy = OCC_W'($countones(w_v));
  assign bus.sat_flag  = r_sat_flag;

endmodule

// File: tb/tb_simple_pipe.sv
// tb/tb_simple_pipe.sv - randomized scoreboard bench for simple_pipe
// Expected outputs follow SIMPLE_PIPE_SAT_EN the same way as the design build.
module tb_simple_pipe;
  import simple_pipe_pkg::*;

  localparam int W     = DEF_WIDTH;
  localparam int D     = DEF_DEPTH;
  localparam int TOTAL = (DEF_DEPTH - 2) * DEF_STEP + DEF_FINAL_ADD;
  localparam int MAXV  = (1 << W) - 1;

  logic clk;
  logic reset;

  simple_pipe_if #(.WIDTH(W), .DEPTH(D)) bus ();

  simple_pipe #(
    .WIDTH(W), .DEPTH(D), .STEP(DEF_STEP), .FINAL_ADD(DEF_FINAL_ADD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  function automatic logic [W-1:0] ref_out(input logic [W-1:0] x);
    int s;
    s = int'(x) + TOTAL;
`ifdef SIMPLE_PIPE_SAT_EN
    if (s > MAXV) s = MAXV;
`endif
    return W'(s % (MAXV + 1));
  endfunction

  logic [W-1:0] tx_q   [$];
  logic [W-1:0] exp_q  [$];
  logic [W-1:0] rx_log [$];
  int           rxc_log[$];
  int           p_valid = 100;
  int           p_ready = 100;
  bit           acc_flag = 0;
  bit           stall_prev = 0;
  bit           exp_sat = 0;
  logic [W-1:0] held;
  int           cyc = 0;
  int           n_out = 0;
  int           n_acc = 0;
  int           acc_cyc = 0;

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  // Reference scoreboard: words in flight are exactly those accepted and not yet emitted.
  always @(negedge clk) begin
    acc_flag = 0;
    cyc++;
    if (reset) begin
      exp_q.delete();
      stall_prev = 0;
      exp_sat = 0;
    end else begin
      check("occupancy", 32'(bus.occupancy), exp_q.size());
      check("in_ready", 32'(bus.in_ready), 32'(!(exp_q.size() == D && !bus.out_ready)));
      if (stall_prev) begin
        check("stall_valid", 32'(bus.out_valid), 1);
        check("stall_data", 32'(bus.out_data), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) check("spurious_out", 1, 0);
        else check("out_data", 32'(bus.out_data), 32'(exp_q.pop_front()));
        rx_log.push_back(bus.out_data);
        rxc_log.push_back(cyc);
        n_out++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(ref_out(bus.in_data));
`ifdef SIMPLE_PIPE_SAT_EN
        if (int'(bus.in_data) + TOTAL > MAXV) exp_sat = 1;
`endif
        acc_flag = 1;
        acc_cyc = cyc;
        n_acc++;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held = bus.out_data;
    end
  end

  initial begin
    logic [W-1:0] dummy;
    bus.in_valid  = 0;
    bus.in_data   = '0;
    bus.out_ready = 0;
    forever begin
      @(posedge clk);
      #1;
      if (acc_flag && tx_q.size() > 0) dummy = tx_q.pop_front();
      bus.out_ready = ($urandom_range(99) < p_ready);
      if (tx_q.size() > 0 && $urandom_range(99) < p_valid) begin
        bus.in_valid = 1;
        bus.in_data  = tx_q[0];
      end else begin
        bus.in_valid = 0;
        bus.in_data  = W'($urandom);
      end
    end
  end

  task automatic wait_cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while ((tx_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check(tag, 32'(tx_q.size() == 0 && exp_q.size() == 0), 1);
  endtask

  initial begin
    int base_out;
    int base_acc;
    reset = 1;
    repeat (3) @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    #1;
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_out_data", 32'(bus.out_data), 0);
    check("rst_occupancy", 32'(bus.occupancy), 0);
    check("rst_in_ready", 32'(bus.in_ready), 1);
    check("rst_sat_flag", 32'(bus.sat_flag), 0);

    // single word latency
    rx_log.delete(); rxc_log.delete();
    base_out = n_out;
    p_valid = 100; p_ready = 100;
    tx_q.push_back(8'd10);
    drain("t1_drain", 50);
    wait_cycles(2);
    check("t1_count", n_out - base_out, 1);
    if (rx_log.size() > 0) check("t1_data", 32'(rx_log[0]), 15);
    if (rxc_log.size() > 0) check("t1_latency", rxc_log[0] - acc_cyc, D);
    check("t1_occ_end", 32'(bus.occupancy), 0);

    // back-to-back stream
    rx_log.delete(); rxc_log.delete();
    base_out = n_out;
    for (int i = 0; i < 20; i++) tx_q.push_back(W'(i));
    wait_cycles(10);
    check("t2_occ_steady", 32'(bus.occupancy), D);
    drain("t2_drain", 100);
    wait_cycles(2);
    check("t2_count", n_out - base_out, 20);
    if (rx_log.size() == 20) begin
      check("t2_first", 32'(rx_log[0]), 5);
      check("t2_last", 32'(rx_log[19]), 24);
      check("t2_span", rxc_log[19] - rxc_log[0], 19);
    end else check("t2_size", rx_log.size(), 20);

    // fill against a stalled output
    rx_log.delete(); rxc_log.delete();
    base_acc = n_acc;
    p_ready = 0;
    for (int i = 1; i <= 7; i++) tx_q.push_back(W'(i));
    wait_cycles(12);
    check("t3_accepted", n_acc - base_acc, D);
    check("t3_in_ready", 32'(bus.in_ready), 0);
    check("t3_occ_full", 32'(bus.occupancy), D);
    p_ready = 100;
    drain("t3_drain", 100);
    check("t3_size", rx_log.size(), 7);
    for (int i = 0; i < 7 && i < rx_log.size(); i++) check("t3_order", 32'(rx_log[i]), 6 + i);

    // wrap / saturation boundary
    rx_log.delete(); rxc_log.delete();
    tx_q.push_back(8'd250);
    tx_q.push_back(8'd253);
    drain("t4_drain", 50);
    wait_cycles(2);
    if (rx_log.size() == 2) begin
      check("t4_250", 32'(rx_log[0]), 255);
`ifdef SIMPLE_PIPE_SAT_EN
      check("t4_253", 32'(rx_log[1]), 255);
`else
      check("t4_253", 32'(rx_log[1]), 2);
`endif
    end else check("t4_size", rx_log.size(), 2);
    check("t4_sat_flag", 32'(bus.sat_flag), 32'(exp_sat));
    tx_q.push_back(8'd1);
    drain("t4_drain2", 50);
    wait_cycles(2);
    check("t4_sat_sticky", 32'(bus.sat_flag), 32'(exp_sat));

    // random handshake traffic
    rx_log.delete(); rxc_log.delete();
    base_out = n_out;
    base_acc = n_acc;
    p_valid = 70; p_ready = 60;
    for (int i = 0; i < 1000; i++) tx_q.push_back(W'($urandom));
    drain("t5_drain", 20000);
    check("t5_accepted", n_acc - base_acc, 1000);
    check("t5_emitted", n_out - base_out, 1000);
    check("t5_sat_flag", 32'(bus.sat_flag), 32'(exp_sat));

    // reset with words in flight
    p_valid = 100; p_ready = 0;
    for (int i = 0; i < 3; i++) tx_q.push_back(W'(40 + i));
    wait_cycles(8);
    check("t6_occ_before", 32'(bus.occupancy), 3);
    tx_q.push_back(8'd77);
    @(posedge clk);
    #2 reset = 1;
    @(negedge clk);
    tx_q.delete();
    p_valid = 0;
    @(posedge clk);
    #2 reset = 0;
    @(negedge clk);
    #1;
    check("t6_occupancy", 32'(bus.occupancy), 0);
    check("t6_out_valid", 32'(bus.out_valid), 0);
    check("t6_out_data", 32'(bus.out_data), 0);
    check("t6_in_ready", 32'(bus.in_ready), 1);
    check("t6_sat_flag", 32'(bus.sat_flag), 0);
    base_out = n_out;
    p_ready = 100;
    wait_cycles(12);
    check("t6_no_output", n_out - base_out, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
